alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

- Two-requester scheduler in front of the single 64-bit ALU datapath (adder/subtractor with `B_inv`, AND, OR, XOR selected by `SEL1`/`SEL0`).
- Arbitrates round-robin between the two requesters, registers operands, drives the ALU control and operand ports, and captures `OUT`/`Ov`.
- Returns each result on that requester's response channel with valid/ready backpressure.
- Sits between the issue logic and the ALU, so the ALU needs no handshake of its own.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted when `valid&ready`.
- `req_op0`, `req_op1`  in  3  `{b_inv, sel1, sel0}`.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH  operands.
- `rsp_valid[1:0]`  out  2  response valid.
- `rsp_ready[1:0]`  in  2  response consumed.
- `rsp_data`  out  WIDTH  result; shared, qualified by `rsp_valid`.
- `rsp_ov`  out  1  overflow; add/sub only, forced 0 for logic ops.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `A`/`B`.
- `alu_b_inv`, `alu_sel0`, `alu_sel1`  out  1  to ALU controls.
- `alu_out`  in  WIDTH  from ALU `OUT`.
- `alu_ov`  in  1  from ALU `Ov`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
Op encoding:
- `sel1,sel0 = 00`: `b_inv=0` gives A+B; `b_inv=1` gives A−B.
- `01` AND, `10` OR, `11` XOR. `b_inv` is ignored for logic ops and is driven to 0 on `alu_b_inv`.

FSM states IDLE, EXEC, RESP:
- **IDLE:** The arbiter picks a winner from `req_valid`, and only the winner's `req_ready` is high (combinational). On the handshake, store op, A, B and the winner id, then go to EXEC. With no valid request, stay in IDLE.
- **EXEC:** ALU ports are driven from the operand registers. This state lasts one cycle so the combinational ALU settles. At the end of the cycle, capture `alu_out` into `rsp_data` and `alu_ov & (sel==00)` into `rsp_ov`, then go to RESP.
- **RESP:** `rsp_valid[id]=1`. Data is held stable until `rsp_ready[id]`. On the handshake, clear `rsp_valid` and return to IDLE.

Arbitration:
- Round-robin via a `last_grant` flag that is updated on each accepted request.
- When both requesters are valid, grant the one that was not granted last. A single valid requester wins regardless of the flag.
- `last_grant` resets to 1, so requester 0 wins the first contention.

Other rules:
- `req_ready` is 0 in EXEC and RESP; no new request is accepted until the response completes.
- `alu_*` outputs are registered and hold their last values outside EXEC.
- Reset values: state IDLE; `req_ready`, `rsp_valid`, `rsp_ov`, `busy` = 0; `rsp_data`, `alu_a`, `alu_b`, `alu_b_inv`, `alu_sel0`, `alu_sel1` = 0; `last_grant` = 1.

## Timing
- Request accepted at edge N. EXEC runs in cycle N+1, and `rsp_valid` is high from cycle N+2.
- Best-case throughput is one op every 3 cycles: accept, EXEC, then RESP with `rsp_ready` already high, then back to IDLE.
- Backpressure: with `rsp_ready` low, RESP holds indefinitely and `rsp_data`/`rsp_ov` do not change.
- A requester dropping `req_valid` before it is granted is allowed; nothing is captured.
- Reset mid-operation (EXEC or RESP): the next cycle is IDLE with all outputs at reset values. The in-flight op is discarded and no response is issued.
- `rsp_ready` asserted for the non-owning requester has no effect.

## Structure
- Shared package `alu_pkg` holds:
  - the op encoding constants `OP_ADD=3'b000`, `OP_SUB=3'b100`, `OP_AND=3'b001`, `OP_OR=3'b010`, `OP_XOR=3'b011`;
  - the FSM state enum;
  - `WIDTH` default 64.
- One sub-module, `rr_arb2`: a 2-way round-robin arbiter.
  - Inputs `req[1:0]` and `update`.
  - Outputs `gnt[1:0]` (one-hot or zero) and the registered `last_grant`.
- The FSM, operand registers and response registers stay in `alu_share_ctrl`.
- The bench instantiates the real ALU on the `alu_*` ports.

## Test plan
- **Reset:** assert `rst` 2 cycles with `req_valid=2'b11`. During reset all outputs are 0 and `busy=0`. In the first cycle after reset, `req_ready=2'b01`.
- **Add, requester 0:** A=0x10, B=0x4, op=ADD accepted at N. `rsp_valid=2'b01` at N+2 with `rsp_data=0x14`, `rsp_ov=0`.
- **Subtract, requester 1:** A=0x10, B=0x4, op=SUB. `rsp_data=0xC`.
- **Overflow:**
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1, op=ADD gives `rsp_data=0x8000_0000_0000_0000`, `rsp_ov=1`.
  - Then op=AND with the same operands gives `rsp_ov=0`.
- **Contention:**
  - Both requesters valid continuously: req0 AND 0xF0/0xFF0 gives 0xF0; req1 XOR 0xF0/0xFF0 gives 0xF00. Grant order is 0,1,0,1.
  - Repeat with OR: 0xFF0.
- **Backpressure and reset:**
  - Hold `rsp_ready=0` for 5 cycles in RESP: `rsp_data` stays stable and `req_ready=0` throughout.
  - Then assert `rst` in the EXEC of the next op: the next cycle is IDLE, no `rsp_valid` appears, and `busy=0`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU scheduler: op encodings,
// FSM states and the default datapath width.
package alu_pkg;

  localparam int WIDTH = 64;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Overflow is only meaningful for the adder/subtractor selection.
  function automatic logic is_arith(input logic [1:0] sel);
    return (sel == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant remembers the most recent winner
// so contention alternates, starting with requester 0 after reset.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       last_grant
);

  logic r_last_grant;

  // Grant selection: a lone requester always wins, contention favours the other side.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = r_last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Winner history, advanced only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (update) begin
      r_last_grant <= gnt[1];
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign last_grant = r_last_grant;

endmodule

// File: rtl/alu_share_ctrl.sv
// Scheduler sharing one combinational ALU between two requesters:
// arbitrate, drive the ALU for one cycle, then hold the result until consumed.
module alu_share_ctrl #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ov,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_b_inv,
  output logic             alu_sel0,
  output logic             alu_sel1,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ov,
  output logic             busy
);

  import alu_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       w_gnt;
  logic             w_owner;
  logic             w_accept;
  logic             w_rsp_done;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ov;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_b_inv;
  logic [1:0]       r_alu_sel;

  // last_grant is updated on every accept, so it also names the in-flight owner.
  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .update     (w_accept),
    .gnt        (w_gnt),
    .last_grant (w_owner)
  );

  assign w_op       = w_gnt[1] ? req_op1 : req_op0;
  assign w_a        = w_gnt[1] ? req_a1  : req_a0;
  assign w_b        = w_gnt[1] ? req_b1  : req_b0;
  assign w_accept   = (r_state == ST_IDLE) && (|(req_valid & req_ready));
  assign w_rsp_done = |(r_rsp_valid & rsp_ready);

  // Next-state and request-ready decode.
  always_comb begin
    req_ready = 2'b00;
    w_next    = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rst) begin
          req_ready = 2'b00;
        end else begin
          req_ready = w_gnt;
        end
        if (w_accept) begin
          w_next = ST_EXEC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (w_rsp_done) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand capture feeds the ALU directly; results latched at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_b_inv <= 1'b0;
      r_alu_sel   <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_ov    <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      if (w_accept) begin
        r_alu_a     <= w_a;
        r_alu_b     <= w_b;
        r_alu_b_inv <= (w_op == OP_SUB);
        r_alu_sel   <= w_op[1:0];
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data  <= alu_out;
        r_rsp_ov    <= alu_ov & is_arith(r_alu_sel);
        r_rsp_valid <= w_owner ? 2'b10 : 2'b01;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 2'b00;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_ov    = r_rsp_ov;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_b_inv = r_alu_b_inv;
  assign alu_sel0  = r_alu_sel[0];
  assign alu_sel1  = r_alu_sel[1];
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the scheduler.
module tb_alu_share_ctrl;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_ov;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_b_inv, alu_sel0, alu_sel1;
  logic [W-1:0] alu_out;
  logic         alu_ov;
  logic         busy;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ov(rsp_ov),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_b_inv(alu_b_inv), .alu_sel0(alu_sel0), .alu_sel1(alu_sel1),
    .alu_out(alu_out), .alu_ov(alu_ov), .busy(busy)
  );

  // The shared ALU: adder with B inversion plus carry-in, and three logic ops.
  logic [W-1:0] w_bx, w_sum;
  assign w_bx   = alu_b ^ {W{alu_b_inv}};
  assign w_sum  = alu_a + w_bx + {{(W-1){1'b0}}, alu_b_inv};
  assign alu_ov = (alu_a[W-1] == w_bx[W-1]) && (w_sum[W-1] != alu_a[W-1]);
  always_comb begin
    case ({alu_sel1, alu_sel0})
      2'b00:   alu_out = w_sum;
      2'b01:   alu_out = alu_a & alu_b;
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Model state: one in-flight transaction at most.
  bit           m_known = 1'b0;
  bit           m_last  = 1'b1;
  bit           m_pend  = 1'b0;
  int           m_age   = 0;
  bit           m_id    = 1'b0;
  logic [W-1:0] m_res, m_rsp_data, m_alu_a, m_alu_b;
  logic         m_res_ov, m_rsp_ov, m_alu_binv;
  logic [1:0]   m_alu_sel;

  logic [1:0]   s_req_ready, s_rsp_valid;
  logic [W-1:0] s_rsp_data;
  logic         s_rsp_ov, s_busy;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: expected event never occurred", nm);
  endtask

  // Reference arithmetic from the op rules; overflow from operand/result signs.
  task automatic predict(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic ov);
    ov = 1'b0;
    case (op[1:0])
      2'b00: begin
        if (op[2]) begin
          res = a - b;
          ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end else begin
          res = a + b;
          ov  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end
      end
      2'b01:   res = a & b;
      2'b10:   res = a | b;
      default: res = a ^ b;
    endcase
  endtask

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic step();
    logic [1:0] e_ready, e_rv, acc;
    logic [2:0] op;
    logic [W-1:0] a, b;
    @(negedge clk);
    s_req_ready = req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    s_rsp_ov    = rsp_ov;
    s_busy      = busy;
    if (rst || m_pend) e_ready = 2'b00;
    else if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
    else e_ready = req_valid;
    e_rv = (m_pend && m_age >= 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    if (m_known) begin
      chk("req_ready", s_req_ready, e_ready);
      chk("rsp_valid", s_rsp_valid, e_rv);
      chk("busy", s_busy, m_pend);
      chk("rsp_data", s_rsp_data, m_rsp_data);
      chk("rsp_ov", s_rsp_ov, m_rsp_ov);
      chk("alu_a", alu_a, m_alu_a);
      chk("alu_b", alu_b, m_alu_b);
      chk("alu_ctl", {alu_b_inv, alu_sel1, alu_sel0}, {m_alu_binv, m_alu_sel});
    end
    acc = req_valid & e_ready;
    if (rst) begin
      m_known = 1'b1; m_pend = 1'b0; m_last = 1'b1;
      m_rsp_data = '0; m_rsp_ov = 1'b0;
      m_alu_a = '0; m_alu_b = '0; m_alu_binv = 1'b0; m_alu_sel = 2'b00;
    end else if (m_pend) begin
      if (m_age == 0) begin
        m_age = 1;
        m_rsp_data = m_res;
        m_rsp_ov   = m_res_ov;
      end else if (rsp_ready[m_id]) begin
        m_pend = 1'b0;
      end
    end else if (acc != 2'b00) begin
      m_id   = acc[1];
      m_last = m_id;
      op = m_id ? req_op1 : req_op0;
      a  = m_id ? req_a1  : req_a0;
      b  = m_id ? req_b1  : req_b0;
      predict(op, a, b, m_res, m_res_ov);
      m_pend = 1'b1; m_age = 0;
      m_alu_a = a; m_alu_b = b;
      m_alu_sel  = op[1:0];
      m_alu_binv = (op[1:0] == 2'b00) ? op[2] : 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 1) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
  endtask

  // Single request with literal expected result.
  task automatic run_op(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_ov, input string nm);
    bit got = 1'b0;
    set_req(id, op, a, b);
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    rsp_ready = 2'b11;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if ((s_req_ready & req_valid) != 2'b00) req_valid = 2'b00;
      if (s_rsp_valid[id]) begin
        chk({nm, "_data"}, s_rsp_data, exp_d);
        chk({nm, "_ov"}, s_rsp_ov, exp_ov);
        got = 1'b1;
      end
    end
    if (!got) fail_now({nm, "_timeout"});
    req_valid = 2'b00;
  endtask

  // Both requesters valid continuously; first four grants must alternate 0,1,0,1.
  task automatic contend(input logic [2:0] op0, input logic [2:0] op1,
                         input logic [W-1:0] e0, input logic [W-1:0] e1, input string nm);
    logic [3:0] order = 4'b0000;
    int ng = 0;
    int nr = 0;
    set_req(0, op0, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0FF0);
    set_req(1, op1, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0FF0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      step();
      if ((s_req_ready & req_valid) != 2'b00 && ng < 4) begin
        order[3-ng] = s_req_ready[1];
        ng++;
      end
      if (s_rsp_valid == 2'b01) begin chk({nm, "_r0"}, s_rsp_data, e0); nr++; end
      if (s_rsp_valid == 2'b10) begin chk({nm, "_r1"}, s_rsp_data, e1); nr++; end
    end
    req_valid = 2'b00;
    if (nr < 4) fail_now({nm, "_timeout"});
    chk({nm, "_order"}, order, 4'b0101);
  endtask

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(3))
      0:       return {$urandom, $urandom};
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {56'h0, 8'($urandom)};
    endcase
  endfunction

  initial begin
    bit got;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    set_req(0, 3'b000, '0, '0);
    set_req(1, 3'b000, '0, '0);

    // Reset with both requesters valid
    step();
    step();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_ready", s_req_ready, 2'b00);
    chk("rst_rspv", s_rsp_valid, 2'b00);
    rst = 1'b0;
    step();
    chk("post_rst_ready", s_req_ready, 2'b01);
    req_valid = 2'b00; rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) step();

    run_op(0, 3'b000, 64'h10, 64'h4, 64'h14, 1'b0, "add_r0");
    run_op(1, 3'b100, 64'h10, 64'h4, 64'hC, 1'b0, "sub_r1");
    run_op(1, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1, "ovf_add");
    run_op(1, 3'b001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b0, "ovf_and");

    contend(3'b001, 3'b011, 64'hF0, 64'hF00, "cont_andxor");
    contend(3'b010, 3'b010, 64'hFF0, 64'hFF0, "cont_or");

    // Backpressure, then reset during EXEC of the following op
    set_req(0, 3'b000, 64'h100, 64'h23);
    set_req(1, 3'b011, 64'h5, 64'h6);
    req_valid = 2'b01; rsp_ready = 2'b00;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if ((s_req_ready & req_valid) != 2'b00) req_valid = 2'b00;
      got = s_rsp_valid[0];
    end
    if (!got) fail_now("bp_timeout");
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", s_rsp_data, 64'h123);
      chk("bp_ready", s_req_ready, 2'b00);
      chk("bp_rspv", s_rsp_valid, 2'b01);
    end
    rsp_ready = 2'b01;
    step();
    step();
    chk("bp_next_grant", s_req_ready, 2'b10);
    req_valid = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0; rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_rspv", s_rsp_valid, 2'b00);
      chk("midrst_busy", s_busy, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) == 0);
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      set_req(0, 3'($urandom), rnd64(), rnd64());
      set_req(1, 3'($urandom), rnd64(), rnd64());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
